// File: rtl/magic_pkg.sv
// Shared types for the MAGIC NOR sequencer: gate ops, crossbar commands,
// the packed gate instruction and the FSM state encoding.
package magic_pkg;
  localparam int XB_ADDR_W = 8;

  typedef enum logic [1:0] {
    OP_NOR2 = 2'b00,
    OP_INV1 = 2'b01,
    OP_END  = 2'b10,
    OP_NOP  = 2'b11
  } gate_op_e;

  typedef enum logic [2:0] {
    XB_WR0  = 3'd0,
    XB_WR1  = 3'd1,
    XB_INIT = 3'd2,
    XB_NOR  = 3'd3,
    XB_READ = 3'd4
  } xb_op_e;

  typedef struct packed {
    gate_op_e               op;
    logic [XB_ADDR_W-1:0]   a;
    logic [XB_ADDR_W-1:0]   b;
    logic [XB_ADDR_W-1:0]   o;
  } instr_t;

  typedef struct packed {
    xb_op_e                 op;
    logic [XB_ADDR_W-1:0]   a;
    logic [XB_ADDR_W-1:0]   b;
    logic [XB_ADDR_W-1:0]   o;
  } xb_cmd_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FETCH, S_DECODE, S_INIT, S_EVAL, S_READ, S_WAIT_RD, S_FIN
  } state_e;

  function automatic xb_cmd_t mk_cmd(xb_op_e op, logic [XB_ADDR_W-1:0] a,
                                     logic [XB_ADDR_W-1:0] b, logic [XB_ADDR_W-1:0] o);
    mk_cmd = '{op: op, a: a, b: b, o: o};
  endfunction
endpackage

// File: rtl/magic_cmd_reg.sv
// Valid/ready holding register for crossbar commands; payload is frozen while
// valid is high and zeroed once accepted so unused columns read 0.
module magic_cmd_reg
  import magic_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load_i,
  input  xb_cmd_t cmd_i,
  input  logic    ready_i,
  output logic    valid_o,
  output xb_cmd_t cmd_o,
  output logic    accept_o
);
  logic    valid_q;
  xb_cmd_t cmd_q;

  // load_i is only raised when the register is empty or draining this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      cmd_q   <= cmd_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
    end
  end

  assign valid_o  = valid_q;
  assign cmd_o    = cmd_q;
  assign accept_o = valid_q && ready_i;
endmodule

// File: rtl/magic_nor_sequencer.sv
// Walks a NOR/INV gate program: loads primary inputs, then INIT+NOR per gate,
// then reads OUT_COL. Commands go out through a single holding register.
module magic_nor_sequencer
  import magic_pkg::*;
#(
  parameter int ADDR_W  = XB_ADDR_W,
  parameter int PC_W    = 8,
  parameter int N_PI    = 10,
  parameter int OUT_COL = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_PI-1:0]       pi_data,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [2+3*ADDR_W-1:0] imem_data,
  output logic                  xb_cmd_valid,
  input  logic                  xb_cmd_ready,
  output logic [2:0]            xb_cmd_op,
  output logic [ADDR_W-1:0]     xb_col_a,
  output logic [ADDR_W-1:0]     xb_col_b,
  output logic [ADDR_W-1:0]     xb_col_o,
  input  logic                  xb_rd_valid,
  input  logic                  xb_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  result,
  output logic                  err,
  output logic [PC_W-1:0]       gate_count
);
  localparam int              IW     = (N_PI > 1) ? $clog2(N_PI) : 1;
  localparam logic [PC_W-1:0] PC_MAX = '1;
  localparam logic [IW-1:0]   IDX_LAST = IW'(N_PI - 1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, gcnt_q, gcnt_d;
  logic [IW-1:0]       idx_q, idx_d, idx_nxt;
  logic [N_PI-1:0]     pi_q, pi_d;
  logic [ADDR_W-1:0]   ga_q, ga_d, gb_q, gb_d, go_q, go_d;
  logic                result_q, result_d, err_q, err_d;
  logic                busy_q, busy_d, done_q, done_d;

  instr_t              ins;
  logic [ADDR_W-1:0]   b_eff;
  logic                cmd_load, accept;
  xb_cmd_t             cmd_d, cmd_q;

  assign ins     = instr_t'(imem_data);
  assign b_eff   = (ins.op == OP_INV1) ? ins.a : ins.b;
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    gcnt_d   = gcnt_q;
    idx_d    = idx_q;
    pi_d     = pi_q;
    ga_d     = ga_q;
    gb_d     = gb_q;
    go_d     = go_q;
    result_d = result_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cmd_load = 1'b0;
    cmd_d    = '0;
    unique case (state_q)
      S_IDLE: if (start) begin
        pi_d     = pi_data;
        err_d    = 1'b0;
        gcnt_d   = '0;
        pc_d     = '0;
        idx_d    = '0;
        busy_d   = 1'b1;
        cmd_load = 1'b1;
        cmd_d    = mk_cmd(pi_data[0] ? XB_WR1 : XB_WR0, '0, '0, '0);
        state_d  = S_LOAD;
      end
      S_LOAD: if (accept) begin
        if (idx_q == IDX_LAST) state_d = S_FETCH;
        else begin
          idx_d    = idx_nxt;
          cmd_load = 1'b1;
          cmd_d    = mk_cmd(pi_q[idx_nxt] ? XB_WR1 : XB_WR0, ADDR_W'(idx_nxt), '0, '0);
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (ins.op == OP_END) begin
          cmd_load = 1'b1;
          cmd_d    = mk_cmd(XB_READ, ADDR_W'(OUT_COL), '0, '0);
          state_d  = S_READ;
        end else if (pc_q == PC_MAX || ins.a == ins.o || b_eff == ins.o) begin
          // no further program space, or a gate that would clobber its own input
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else if (ins.op == OP_NOP) begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          ga_d     = ins.a;
          gb_d     = b_eff;
          go_d     = ins.o;
          cmd_load = 1'b1;
          cmd_d    = mk_cmd(XB_INIT, '0, '0, ins.o);
          state_d  = S_INIT;
        end
      end
      S_INIT: if (accept) begin
        cmd_load = 1'b1;
        cmd_d    = mk_cmd(XB_NOR, ga_q, gb_q, go_q);
        state_d  = S_EVAL;
      end
      S_EVAL: if (accept) begin
        pc_d    = pc_q + 1'b1;
        gcnt_d  = gcnt_q + 1'b1;
        state_d = S_FETCH;
      end
      S_READ: if (accept) state_d = S_WAIT_RD;
      S_WAIT_RD: if (xb_rd_valid) begin
        result_d = xb_rd_data;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      gcnt_q   <= '0;
      idx_q    <= '0;
      pi_q     <= '0;
      ga_q     <= '0;
      gb_q     <= '0;
      go_q     <= '0;
      result_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      gcnt_q   <= gcnt_d;
      idx_q    <= idx_d;
      pi_q     <= pi_d;
      ga_q     <= ga_d;
      gb_q     <= gb_d;
      go_q     <= go_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  magic_cmd_reg u_cmd (
    .clk      (clk),
    .rst      (rst),
    .load_i   (cmd_load),
    .cmd_i    (cmd_d),
    .ready_i  (xb_cmd_ready),
    .valid_o  (xb_cmd_valid),
    .cmd_o    (cmd_q),
    .accept_o (accept)
  );

  assign xb_cmd_op  = cmd_q.op;
  assign xb_col_a   = cmd_q.a;
  assign xb_col_b   = cmd_q.b;
  assign xb_col_o   = cmd_q.o;
  assign imem_addr  = pc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign err        = err_q;
  assign gate_count = gcnt_q;
endmodule
